riscv_state_dump: RTL

- Synthesizable debug-access unit for the RISC_V core.
- Halts the core, then does one of two things:
  - streams register-file and/or data-memory contents out over a valid/ready word stream;
  - preloads the register file from an input stream.
- Replaces bench-side hierarchical preload and dump with a parametrised hardware path that works in simulation and on silicon.
- Sits beside the core on the register-file and data-memory debug ports.

---
 rtl/riscv_state_dump.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_state_dump.sv
// Debug access unit: halts the core, then dumps regfile/dmem over a
// valid/ready stream or preloads the regfile from an input stream.
module riscv_state_dump #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int RIDX_W    = 5,
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [MEM_AW-1:0] mem_base,
  input  logic [MEM_AW:0]   mem_count,
  output logic              busy,
  output logic              done,
  output logic              core_halt,
  input  logic              halt_ack,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              dm_re,
  output logic [MEM_AW-1:0] dm_raddr,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_tag,
  output logic              out_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_data
);

  typedef enum logic [2:0] {
    IDLE, HALT_WAIT, REG_DUMP, MEM_REQ,
    MEM_CAP, REG_LOAD, FINISH
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_REG =
    RIDX_W'(NREGS - 1);
  localparam logic [MEM_AW-1:0] LAST_ADDR =
    MEM_AW'(MEM_DEPTH - 1);

  state_t              state;
  logic [1:0]          mode_q;
  logic [MEM_AW-1:0]   base_q;
  logic [MEM_AW:0]     count_q;
  logic [MEM_AW:0]     j;
  logic [RIDX_W-1:0]   k;
  logic                tail;

  logic                can_load;
  logic                in_hs;
  logic                reg_last;
  logic                mem_last;
  logic                to_mem;
  logic [MEM_AW-1:0]   next_addr;

  assign can_load  = !out_valid || out_ready;
  assign in_hs     = (state == REG_LOAD) &&
                     in_valid && in_ready;
  assign rf_we     = in_hs && (k != '0);
  assign rf_waddr  = in_hs ? k : '0;
  assign rf_wdata  = in_hs ? in_data : '0;
  assign reg_last  = (mode_q == 2'd0) ||
                     (mode_q == 2'd2 && count_q == '0);
  assign to_mem    = (mode_q == 2'd2) && (count_q != '0);
  assign mem_last  = (j == count_q - (MEM_AW+1)'(1));
  assign next_addr = (dm_raddr == LAST_ADDR) ? '0 :
                     dm_raddr + MEM_AW'(1);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      j         <= '0;
      k         <= '0;
      tail      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      core_halt <= 1'b0;
      rf_raddr  <= '0;
      dm_re     <= 1'b0;
      dm_raddr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      done  <= 1'b0;
      dm_re <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            base_q    <= mem_base;
            count_q   <= mem_count;
            core_halt <= 1'b1;
            busy      <= 1'b1;
            state     <= HALT_WAIT;
          end
        end
        HALT_WAIT: begin
          if (halt_ack) begin
            unique case (mode_q)
              2'd0, 2'd2: begin
                rf_raddr <= '0;
                tail     <= 1'b0;
                state    <= REG_DUMP;
              end
              2'd1: begin
                if (count_q == '0) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  core_halt <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= FINISH;
                end else begin
                  dm_re    <= 1'b1;
                  dm_raddr <= base_q;
                  j        <= '0;
                  tail     <= 1'b0;
                  state    <= MEM_REQ;
                end
              end
              2'd3: begin
                k        <= '0;
                in_ready <= 1'b1;
                state    <= REG_LOAD;
              end
            endcase
          end
        end
        REG_DUMP: begin
          if (!tail) begin
            if (can_load) begin
              out_valid <= 1'b1;
              out_data  <= rf_rdata;
              out_tag   <= 1'b0;
              out_last  <= (rf_raddr == LAST_REG) && reg_last;
              if (rf_raddr == LAST_REG)
                tail <= 1'b1;
              else
                rf_raddr <= rf_raddr + RIDX_W'(1);
            end
          end else if (out_ready) begin
            if (to_mem) begin
              dm_re    <= 1'b1;
              dm_raddr <= base_q;
              j        <= '0;
              tail     <= 1'b0;
              state    <= MEM_REQ;
            end else begin
              done      <= 1'b1;
              busy      <= 1'b0;
              core_halt <= 1'b0;
              out_valid <= 1'b0;
              state     <= FINISH;
            end
          end
        end
        MEM_REQ: begin
          state <= MEM_CAP;
        end
        MEM_CAP: begin
          if (tail) begin
            if (out_ready) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              core_halt <= 1'b0;
              out_valid <= 1'b0;
              state     <= FINISH;
            end
          end else if (can_load) begin
            out_valid <= 1'b1;
            out_data  <= dm_rdata;
            out_tag   <= 1'b1;
            out_last  <= mem_last;
            if (mem_last) begin
              tail <= 1'b1;
            end else begin
              j        <= j + (MEM_AW+1)'(1);
              dm_raddr <= next_addr;
              dm_re    <= 1'b1;
              state    <= MEM_REQ;
            end
          end
        end
        REG_LOAD: begin
          if (in_hs) begin
            if (k == LAST_REG) begin
              in_ready  <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              core_halt <= 1'b0;
              out_valid <= 1'b0;
              state     <= FINISH;
            end else begin
              k <= k + RIDX_W'(1);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
